fwd_hazard_unit: RTL and testbench
==================================

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter NUM_SRC, default 2, meaning source operands per instruction (1..3).
REQ-002 Parameter FWD_STAGES, default 2, meaning forwarding-capable stages after EX; index 0 = EX/MEM (youngest), FWD_STAGES-1 = oldest (2..4).
REQ-003 Parameter RA_W, default 5, meaning register address width.
REQ-004 Parameter LAT_W, default 4, meaning multi-cycle latency counter width.
REQ-005 Derived SEL_W = clog2(FWD_STAGES+1), meaning forward-select width.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 ex_rs  in  NUM_SRC*RA_W  source addresses of instruction in EX; source i at bits [i*RA_W +: RA_W].
REQ-009 id_rs  in  NUM_SRC*RA_W  source addresses of instruction in ID.
REQ-010 id_rs_used  in  NUM_SRC  bit i = ID instruction reads source i.
REQ-011 id_rd  in  RA_W  ID destination.
REQ-012 id_we  in  1  ID instruction writes id_rd.
REQ-013 stage_rd  in  FWD_STAGES*RA_W  destination per forwarding stage.
REQ-014 stage_we  in  FWD_STAGES  register-write enable per stage.
REQ-015 ex_is_load  in  1  EX instruction is a load; ex_rd  in  RA_W  its destination.
REQ-016 mc_start  in  1  one-cycle pulse: multi-cycle op (mul/div) issues from EX.
REQ-017 mc_rd  in  RA_W  destination of issuing multi-cycle op; mc_lat  in  LAT_W  its latency in cycles (>=1).
REQ-018 fwd_sel  out  NUM_SRC*SEL_W  per EX source: 0 = register file, k = stage k-1.
REQ-019 stall_id  out  1  hold PC and IF/ID; bubble_ex  out  1  insert NOP into ID/EX.
REQ-020 mc_busy  out  1  multi-cycle op pending; mc_wb  out  1  one-cycle pulse, result written back.
REQ-021 mc_err  out  1  sticky: mc_start received while busy.

Function
REQ-022 fwd_sel SHALL be combinational: select lowest index k with stage_we[k]=1, stage_rd[k]!=0 and stage_rd[k]==ex_rs[i]; value k+1; else 0.
REQ-023 Source address 0 SHALL never forward or stall.
REQ-024 Load-use: ex_is_load=1, ex_rd!=0, and any used id_rs[i]==ex_rd SHALL assert stall_id=bubble_ex=1 same cycle (combinational); exactly one stall cycle since load then leaves EX.
REQ-025 FSM states IDLE, BUSY; reset state IDLE.
REQ-026 IDLE + mc_start: -> BUSY, latch mc_rd into pend_rd, load counter with mc_lat; mc_lat=0 treated as 1.
REQ-027 BUSY: counter decrements each cycle; on the cycle counter==1, mc_wb=1 and next state IDLE.
REQ-028 mc_busy=1 exactly when state==BUSY.
REQ-029 BUSY, pend_rd!=0: RAW (used id_rs[i]==pend_rd) or WAW (id_we=1, id_rd==pend_rd) SHALL assert stall_id and bubble_ex, including the mc_wb cycle; released the following cycle.
REQ-030 mc_start in BUSY SHALL be ignored (state, counter, pend_rd unchanged) and set mc_err=1 until reset.
REQ-031 mc_start on the mc_wb cycle SHALL be treated as in BUSY (rejected, mc_err set).
REQ-032 stall_id SHALL equal bubble_ex; load-use and multi-cycle stalls OR together.

Reset
REQ-033 rst_n low SHALL asynchronously force state IDLE, counter 0, pend_rd 0, mc_err 0; hence mc_busy=0, mc_wb=0.
REQ-034 Reset asserted mid-BUSY SHALL abandon the pending op with no mc_wb pulse.
REQ-035 Combinational outputs SHALL be driven from inputs during reset; no multi-cycle stall contribution.

Verification
REQ-036 stage_rd={5,5}, stage_we=2'b11, ex_rs[0]=5 -> fwd_sel[0]=1 (youngest wins); stage_we=2'b10 -> 2; ex_rs[0]=0 -> 0.
REQ-037 ex_is_load=1, ex_rd=7, id_rs[1]=7, id_rs_used=2'b10 -> stall_id=bubble_ex=1; id_rs_used=2'b00 -> 0.
REQ-038 mc_start, mc_rd=9, mc_lat=3 at cycle 0 -> mc_busy cycles 1-3, mc_wb at cycle 3; ID reading r9 stalled cycles 1-3, released cycle 4.
REQ-039 mc_start at cycle 2 of REQ-038 op -> ignored, mc_wb still cycle 3, mc_err=1 thereafter until rst_n low.
REQ-040 rst_n low at cycle 2 of REQ-038 op -> mc_busy=0 immediately, no mc_wb, stall released.
REQ-041 BUSY pend_rd=4, id_we=1, id_rd=4, no RAW -> WAW stall; pend_rd=0 -> no stall.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
//
// Purpose:
//   Operand-forwarding select and pipeline-stall generation for an in-order
//   pipeline that also has one multi-cycle functional unit (mul/div).
//   * Forwarding: for every EX source operand, pick the youngest later stage
//     that is writing the register the operand reads.
//   * Load-use: when a load in EX feeds a source that the ID instruction reads,
//     stall ID for the single cycle it takes the load to leave EX.
//   * Multi-cycle scoreboard: while a mul/div is outstanding, stall any ID
//     instruction that reads (RAW) or writes (WAW) its destination, up to and
//     including the write-back cycle.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   i_ex_rs             EX source addresses, source i at [i*RA_W +: RA_W]
//   i_id_rs             ID source addresses, same packing
//   i_id_rs_used        bit i set when the ID instruction reads source i
//   i_id_rd, i_id_we    ID destination and its write enable
//   i_stage_rd          destination per forwarding stage (0 = youngest)
//   i_stage_we          register-write enable per forwarding stage
//   i_ex_is_load,
//   i_ex_rd             EX instruction is a load, and its destination
//   i_mc_start          one-cycle issue pulse for a multi-cycle op
//   i_mc_rd, i_mc_lat   destination and latency of the issuing op
//   o_fwd_sel           per EX source: 0 = register file, k = stage k-1
//   o_stall_id          hold PC and IF/ID
//   o_bubble_ex         insert a NOP into ID/EX (always equals o_stall_id)
//   o_mc_busy           multi-cycle op outstanding
//   o_mc_wb             one-cycle pulse on the write-back cycle
//   o_mc_err            sticky: an issue arrived while busy
//   o_dbg_state         current scoreboard FSM state (0 = IDLE, 1 = BUSY)
//
// Handshake: i_mc_start is a request and ~o_mc_busy is its ready. A request is
// accepted only on a cycle where o_mc_busy is low; a request while o_mc_busy is
// high (including the o_mc_wb cycle) is dropped and flagged on o_mc_err.
// -----------------------------------------------------------------------------
module fwd_hazard_unit #(
    parameter  int NUM_SRC    = 2,
    parameter  int FWD_STAGES = 2,
    parameter  int RA_W       = 5,
    parameter  int LAT_W      = 4,
    localparam int SEL_W      = $clog2(FWD_STAGES + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_SRC*RA_W-1:0]    i_ex_rs,
    input  logic [NUM_SRC*RA_W-1:0]    i_id_rs,
    input  logic [NUM_SRC-1:0]         i_id_rs_used,
    input  logic [RA_W-1:0]            i_id_rd,
    input  logic                       i_id_we,
    input  logic [FWD_STAGES*RA_W-1:0] i_stage_rd,
    input  logic [FWD_STAGES-1:0]      i_stage_we,
    input  logic                       i_ex_is_load,
    input  logic [RA_W-1:0]            i_ex_rd,
    input  logic                       i_mc_start,
    input  logic [RA_W-1:0]            i_mc_rd,
    input  logic [LAT_W-1:0]           i_mc_lat,
    output logic [NUM_SRC*SEL_W-1:0]   o_fwd_sel,
    output logic                       o_stall_id,
    output logic                       o_bubble_ex,
    output logic                       o_mc_busy,
    output logic                       o_mc_wb,
    output logic                       o_mc_err,
    output logic [0:0]                 o_dbg_state
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [0:0]       r_state;
    logic [LAT_W-1:0] r_cnt;
    logic [RA_W-1:0]  r_pend_rd;
    logic             r_err;

    // -------------------------------------------------------------------------
    // Wires
    // -------------------------------------------------------------------------
    logic [NUM_SRC*SEL_W-1:0] w_fwd_sel;
    logic                     w_load_use;
    logic                     w_mc_raw;
    logic                     w_mc_waw;
    logic                     w_mc_stall;
    logic                     w_busy;
    logic                     w_last;
    logic [LAT_W-1:0]         w_lat_eff;

    // -------------------------------------------------------------------------
    // Forwarding select
    // Stages are scanned oldest to youngest so the youngest matching stage is
    // the last writer and therefore wins. A matching stage must have a non-zero
    // destination, which also keeps source r0 from ever forwarding.
    // -------------------------------------------------------------------------
    always_comb begin
        w_fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = FWD_STAGES - 1; k >= 0; k--) begin
                if (i_stage_we[k] &&
                    (i_stage_rd[k*RA_W +: RA_W] != '0) &&
                    (i_stage_rd[k*RA_W +: RA_W] == i_ex_rs[i*RA_W +: RA_W])) begin
                    w_fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
                end
            end
        end
    end

    assign o_fwd_sel = w_fwd_sel;

    // -------------------------------------------------------------------------
    // Load-use hazard
    // A load's data is not forwardable until it leaves EX, so an ID consumer
    // waits exactly one cycle. A zero load destination never stalls.
    // -------------------------------------------------------------------------
    always_comb begin
        w_load_use = 1'b0;
        if (i_ex_is_load && (i_ex_rd != '0)) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (i_id_rs_used[i] && (i_id_rs[i*RA_W +: RA_W] == i_ex_rd)) begin
                    w_load_use = 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Multi-cycle scoreboard hazards
    // The stall is held through the write-back cycle itself because the result
    // only reaches the register file at the end of that cycle.
    // -------------------------------------------------------------------------
    assign w_busy = (r_state == ST_BUSY);
    assign w_last = w_busy && (r_cnt == LAT_W'(1));

    always_comb begin
        w_mc_raw = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (i_id_rs_used[i] && (i_id_rs[i*RA_W +: RA_W] == r_pend_rd)) begin
                w_mc_raw = 1'b1;
            end
        end
    end

    assign w_mc_waw   = i_id_we && (i_id_rd == r_pend_rd);
    assign w_mc_stall = w_busy && (r_pend_rd != '0) && (w_mc_raw || w_mc_waw);

    assign o_stall_id  = w_load_use || w_mc_stall;
    assign o_bubble_ex = w_load_use || w_mc_stall;

    // -------------------------------------------------------------------------
    // Scoreboard FSM
    // A zero latency is promoted to one so every accepted op produces exactly
    // one write-back pulse.
    // -------------------------------------------------------------------------
    assign w_lat_eff = (i_mc_lat == '0) ? LAT_W'(1) : i_mc_lat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_pend_rd <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_mc_start) begin
                        r_state   <= ST_BUSY;
                        r_cnt     <= w_lat_eff;
                        r_pend_rd <= i_mc_rd;
                    end
                end
                ST_BUSY: begin
                    // Any issue while busy is dropped; only the countdown runs.
                    if (w_last) begin
                        r_state   <= ST_IDLE;
                        r_cnt     <= '0;
                        r_pend_rd <= '0;
                    end else begin
                        r_cnt <= r_cnt - LAT_W'(1);
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_cnt     <= '0;
                    r_pend_rd <= '0;
                end
            endcase
        end
    end

    // Sticky protocol-error flag: cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_busy && i_mc_start) begin
            r_err <= 1'b1;
        end
    end

    assign o_mc_busy   = w_busy;
    assign o_mc_wb     = w_last;
    assign o_mc_err    = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

  localparam int NS = 2;
  localparam int FS = 2;
  localparam int RA = 5;
  localparam int LW = 4;
  localparam int SW = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic [NS*RA-1:0] ex_rs, id_rs;
  logic [NS-1:0]    id_rs_used;
  logic [RA-1:0]    id_rd;
  logic             id_we;
  logic [FS*RA-1:0] stage_rd;
  logic [FS-1:0]    stage_we;
  logic             ex_is_load;
  logic [RA-1:0]    ex_rd;
  logic             mc_start;
  logic [RA-1:0]    mc_rd;
  logic [LW-1:0]    mc_lat;
  logic [NS*SW-1:0] fwd_sel;
  logic             stall_id, bubble_ex, mc_busy, mc_wb, mc_err;
  logic [0:0]       dbg_state;

  fwd_hazard_unit #(.NUM_SRC(NS), .FWD_STAGES(FS), .RA_W(RA), .LAT_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_ex_rs(ex_rs), .i_id_rs(id_rs), .i_id_rs_used(id_rs_used),
    .i_id_rd(id_rd), .i_id_we(id_we),
    .i_stage_rd(stage_rd), .i_stage_we(stage_we),
    .i_ex_is_load(ex_is_load), .i_ex_rd(ex_rd),
    .i_mc_start(mc_start), .i_mc_rd(mc_rd), .i_mc_lat(mc_lat),
    .o_fwd_sel(fwd_sel), .o_stall_id(stall_id), .o_bubble_ex(bubble_ex),
    .o_mc_busy(mc_busy), .o_mc_wb(mc_wb), .o_mc_err(mc_err),
    .o_dbg_state(dbg_state)
  );

  // scoreboard counters
  int n_checks = 0;
  int n_fail = 0;

  // reference model: the outstanding op is described by the cycle it was
  // accepted and its length; busy/write-back follow from the cycle number.
  int          cyc = 0;
  bit          have_op = 0;
  int          op_start = 0;
  int          op_len = 0;
  int          op_rd = 0;
  bit          m_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks every output against the model for the current cycle, lets the
  // model see this cycle's issue request, then advances to the next negedge.
  task automatic step(input string tag);
    logic [31:0] e_fwd;
    bit e_busy, e_wb, e_lu, e_mc, e_stall;
    int a, sel, r;
    #1;
    if (!rst_n) begin
      have_op = 0;
      m_err = 0;
    end
    e_busy = have_op && (cyc > op_start) && (cyc <= op_start + op_len);
    e_wb   = have_op && (cyc == op_start + op_len);

    e_fwd = '0;
    for (int i = 0; i < NS; i++) begin
      a = int'(ex_rs[i*RA +: RA]);
      sel = 0;
      for (int k = 0; k < FS; k++) begin
        r = int'(stage_rd[k*RA +: RA]);
        if (sel == 0 && stage_we[k] && r != 0 && r == a) sel = k + 1;
      end
      e_fwd[i*SW +: SW] = SW'(sel);
    end

    e_lu = 0;
    e_mc = 0;
    for (int i = 0; i < NS; i++) begin
      if (id_rs_used[i] && ex_is_load && ex_rd != 0 && id_rs[i*RA +: RA] == ex_rd) e_lu = 1;
      if (id_rs_used[i] && e_busy && op_rd != 0 && int'(id_rs[i*RA +: RA]) == op_rd) e_mc = 1;
    end
    if (e_busy && op_rd != 0 && id_we && int'(id_rd) == op_rd) e_mc = 1;
    e_stall = e_lu || e_mc;

    check({tag, "_fwd"},    32'(fwd_sel),   e_fwd);
    check({tag, "_stall"},  32'(stall_id),  32'(e_stall));
    check({tag, "_bubble"}, 32'(bubble_ex), 32'(e_stall));
    check({tag, "_busy"},   32'(mc_busy),   32'(e_busy));
    check({tag, "_wb"},     32'(mc_wb),     32'(e_wb));
    check({tag, "_err"},    32'(mc_err),    32'(m_err));
    check({tag, "_state"},  32'(dbg_state), 32'(e_busy));

    if (rst_n && mc_start) begin
      if (e_busy) m_err = 1;
      else begin
        have_op = 1;
        op_start = cyc;
        op_len = (mc_lat == 0) ? 1 : int'(mc_lat);
        op_rd = int'(mc_rd);
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    ex_rs = '0; id_rs = '0; id_rs_used = '0; id_rd = '0; id_we = 1'b0;
    stage_rd = '0; stage_we = '0; ex_is_load = 1'b0; ex_rd = '0;
    mc_start = 1'b0; mc_rd = '0; mc_lat = '0;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);

    // reset state
    step("rst0");
    step("rst1");
    rst_n = 1'b1;
    step("idle");

    // forwarding: youngest wins, older stage alone, source r0 never forwards
    stage_rd = {5'd5, 5'd5}; stage_we = 2'b11; ex_rs = {5'd0, 5'd5};
    #1 check("fwd_young", 32'(fwd_sel[1:0]), 32'd1);
    step("fwd_a");
    stage_we = 2'b10;
    #1 check("fwd_old", 32'(fwd_sel[1:0]), 32'd2);
    step("fwd_b");
    ex_rs = {5'd5, 5'd0};
    #1 check("fwd_r0", 32'(fwd_sel[1:0]), 32'd0);
    check("fwd_src1", 32'(fwd_sel[3:2]), 32'd2);
    step("fwd_c");
    stage_rd = {5'd0, 5'd0}; stage_we = 2'b11; ex_rs = '0;
    #1 check("fwd_zero_rd", 32'(fwd_sel), 32'd0);
    step("fwd_d");
    clear_inputs();

    // load-use
    ex_is_load = 1'b1; ex_rd = 5'd7; id_rs = {5'd7, 5'd2}; id_rs_used = 2'b10;
    #1 check("lu_stall", 32'({stall_id, bubble_ex}), 32'b11);
    step("lu_a");
    id_rs_used = 2'b00;
    #1 check("lu_unused", 32'({stall_id, bubble_ex}), 32'b00);
    step("lu_b");
    ex_rd = 5'd0; id_rs = {5'd0, 5'd0}; id_rs_used = 2'b11;
    #1 check("lu_r0", 32'(stall_id), 32'd0);
    step("lu_c");
    clear_inputs();

    // multi-cycle op r9, latency 3, with a rejected second issue at cycle 2
    mc_start = 1'b1; mc_rd = 5'd9; mc_lat = 4'd3; id_rs = {5'd0, 5'd9}; id_rs_used = 2'b01;
    #1 check("mc_c0_busy", 32'({mc_busy, stall_id}), 32'b00);
    step("mc_c0");
    mc_start = 1'b0;
    #1 check("mc_c1", 32'({mc_busy, mc_wb, stall_id}), 32'b101);
    step("mc_c1");
    mc_start = 1'b1; mc_rd = 5'd3; mc_lat = 4'd5;
    #1 check("mc_c2", 32'({mc_busy, mc_wb, stall_id}), 32'b101);
    step("mc_c2");
    mc_start = 1'b0;
    #1 check("mc_c3", 32'({mc_busy, mc_wb, stall_id, mc_err}), 32'b1111);
    step("mc_c3");
    #1 check("mc_c4", 32'({mc_busy, mc_wb, stall_id, mc_err}), 32'b0001);
    step("mc_c4");
    step("mc_c5");
    rst_n = 1'b0;
    #1 check("err_clear", 32'(mc_err), 32'd0);
    step("mc_rst");
    rst_n = 1'b1;

    // reset in the middle of an op
    mc_start = 1'b1; mc_rd = 5'd9; mc_lat = 4'd3;
    step("ab_c0");
    mc_start = 1'b0;
    step("ab_c1");
    rst_n = 1'b0;
    #1 check("ab_c2", 32'({mc_busy, stall_id}), 32'b00);
    step("ab_c2");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check("ab_nowb", 32'(mc_wb), 32'd0);
      step("ab_after");
    end
    clear_inputs();

    // WAW on r4, then pending destination r0 never stalls
    mc_start = 1'b1; mc_rd = 5'd4; mc_lat = 4'd2;
    id_we = 1'b1; id_rd = 5'd4; id_rs = {5'd4, 5'd4}; id_rs_used = 2'b00;
    step("waw_c0");
    mc_start = 1'b0;
    #1 check("waw_c1", 32'(stall_id), 32'd1);
    step("waw_c1");
    #1 check("waw_c2", 32'({mc_wb, stall_id}), 32'b11);
    step("waw_c2");
    #1 check("waw_c3", 32'(stall_id), 32'd0);
    step("waw_c3");
    mc_start = 1'b1; mc_rd = 5'd0; mc_lat = 4'd2; id_rd = 5'd0; id_rs_used = 2'b11;
    id_rs = {5'd0, 5'd0};
    step("z_c0");
    mc_start = 1'b0;
    #1 check("z_c1", 32'({mc_busy, stall_id}), 32'b10);
    step("z_c1");
    step("z_c2");

    // zero latency behaves as one
    mc_start = 1'b1; mc_rd = 5'd6; mc_lat = 4'd0;
    step("l0_c0");
    mc_start = 1'b0;
    #1 check("l0_c1", 32'({mc_busy, mc_wb}), 32'b11);
    step("l0_c1");

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      ex_rs      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      id_rs      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      id_rs_used = 2'($urandom_range(0, 3));
      id_rd      = 5'($urandom_range(0, 7));
      id_we      = 1'($urandom_range(0, 1));
      stage_rd   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      stage_we   = 2'($urandom_range(0, 3));
      ex_is_load = 1'($urandom_range(0, 1));
      ex_rd      = 5'($urandom_range(0, 7));
      mc_start   = ($urandom_range(0, 4) == 0);
      mc_rd      = 5'($urandom_range(0, 7));
      mc_lat     = 4'($urandom_range(0, 6));
      rst_n      = ($urandom_range(0, 80) != 0);
      step("rnd");
      rst_n = 1'b1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
